// File: rtl/fifo_pkg.sv
// Shared helpers for the FIFO status controller: depth derivation and
// elaboration-time parameter legality.
package fifo_pkg;

  function automatic int fifo_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

  function automatic bit fifo_params_ok(input int addr_w, input int afull_th,
                                        input int aempty_th);
    return (addr_w >= 1) &&
           (afull_th >= 1) && (afull_th <= fifo_depth(addr_w)) &&
           (aempty_th >= 0) && (aempty_th <= fifo_depth(addr_w) - 1);
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic afull;
    logic aempty;
  } fifo_flags_t;

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping pointer with enable; one extra MSB beyond the RAM address so
// full and empty stay distinguishable.
module fifo_ptr #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] ptr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     ptr <= '0;
    else if (en) ptr <= ptr + W'(1);
  end

endmodule

// File: rtl/fifo_status_ctrl.sv
// Single-clock FIFO pointer/status controller: request gating, occupancy
// count, registered level flags and sticky overflow/underflow.
module fifo_status_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W    = 4,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic              clr_err,
  output logic              wr_accept,
  output logic              rd_accept,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W:0]   count,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);

  localparam int              DEPTH    = fifo_depth(ADDR_W);
  localparam logic [ADDR_W:0] DEPTH_V  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_V  = (ADDR_W+1)'(AFULL_TH);
  localparam logic [ADDR_W:0] AEMPTY_V = (ADDR_W+1)'(AEMPTY_TH);

  generate
    if (!fifo_params_ok(ADDR_W, AFULL_TH, AEMPTY_TH)) begin : g_param_chk
      $error("fifo_status_ctrl: illegal ADDR_W/AFULL_TH/AEMPTY_TH");
    end
  endgenerate

  logic [ADDR_W:0] wr_ptr, rd_ptr, count_next;
  fifo_flags_t     flg, flg_next;

  // Gating uses only the registered flags, so no request looks ahead.
  assign wr_accept = wr_en & ~flg.full;
  assign rd_accept = rd_en & ~flg.empty;
  assign wr_addr   = wr_ptr[ADDR_W-1:0];
  assign rd_addr   = rd_ptr[ADDR_W-1:0];

  fifo_ptr #(.W(ADDR_W+1)) u_wr_ptr (
    .clk (clk), .rst (rst), .en (wr_accept), .ptr (wr_ptr)
  );

  fifo_ptr #(.W(ADDR_W+1)) u_rd_ptr (
    .clk (clk), .rst (rst), .en (rd_accept), .ptr (rd_ptr)
  );

  always_comb begin
    count_next     = count + {{ADDR_W{1'b0}}, wr_accept}
                           - {{ADDR_W{1'b0}}, rd_accept};
    flg_next       = '0;
    flg_next.full  = (count_next == DEPTH_V);
    flg_next.empty = (count_next == '0);
    flg_next.afull = (count_next >= AFULL_V);
    flg_next.aempty = (count_next <= AEMPTY_V);
  end

  // Error set terms take priority over clr_err in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      flg       <= '{full: 1'b0, empty: 1'b1, afull: 1'b0, aempty: 1'b1};
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= count_next;
      flg       <= flg_next;
      overflow  <= (overflow  & ~clr_err) | (wr_en & flg.full);
      underflow <= (underflow & ~clr_err) | (rd_en & flg.empty);
    end
  end

  assign fifo_full    = flg.full;
  assign fifo_empty   = flg.empty;
  assign almost_full  = flg.afull;
  assign almost_empty = flg.aempty;

  a_count_ptrs: assert property (@(posedge clk) disable iff (rst)
    count == (wr_ptr - rd_ptr));
  a_full_form: assert property (@(posedge clk) disable iff (rst)
    fifo_full == ((wr_ptr ^ rd_ptr) == {1'b1, {ADDR_W{1'b0}}}));

endmodule

// File: tb/tb_fifo_status_ctrl.sv
// Directed scenarios plus random traffic against an occupancy/sequence-number
// model of the FIFO controller.
module tb_fifo_status_ctrl;

  localparam int ADDR_W    = 4;
  localparam int DEPTH     = 16;
  localparam int AFULL_TH  = 12;
  localparam int AEMPTY_TH = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
  logic              wr_accept, rd_accept;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [ADDR_W:0]   count;
  logic              fifo_full, fifo_empty, almost_full, almost_empty;
  logic              overflow, underflow;

  fifo_status_ctrl #(.ADDR_W(ADDR_W), .AFULL_TH(AFULL_TH), .AEMPTY_TH(AEMPTY_TH)) dut (
    .clk (clk), .rst (rst), .wr_en (wr_en), .rd_en (rd_en), .clr_err (clr_err),
    .wr_accept (wr_accept), .rd_accept (rd_accept),
    .wr_addr (wr_addr), .rd_addr (rd_addr), .count (count),
    .fifo_full (fifo_full), .fifo_empty (fifo_empty),
    .almost_full (almost_full), .almost_empty (almost_empty),
    .overflow (overflow), .underflow (underflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: total items ever written/read, and sticky error bits.
  int m_wr = 0, m_rd = 0;
  bit m_ovf = 0, m_udf = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_cnt();
    return m_wr - m_rd;
  endfunction

  task automatic chk_regs(input string tag);
    chk({tag, ".count"}, int'(count), m_cnt());
    chk({tag, ".full"},  int'(fifo_full),    int'(m_cnt() == DEPTH));
    chk({tag, ".empty"}, int'(fifo_empty),   int'(m_cnt() == 0));
    chk({tag, ".afull"}, int'(almost_full),  int'(m_cnt() >= AFULL_TH));
    chk({tag, ".aempty"}, int'(almost_empty), int'(m_cnt() <= AEMPTY_TH));
    chk({tag, ".ovf"},   int'(overflow),  int'(m_ovf));
    chk({tag, ".udf"},   int'(underflow), int'(m_udf));
    chk({tag, ".ptrdiff"}, int'(ADDR_W'(wr_addr - rd_addr)), m_cnt() % DEPTH);
  endtask

  // Entered and left at posedge+1.
  task automatic cycle(input bit w, input bit r, input bit c, input string tag);
    bit exp_wa, exp_ra;
    wr_en = w; rd_en = r; clr_err = c;
    #4;
    exp_wa = w && (m_cnt() < DEPTH);
    exp_ra = r && (m_cnt() > 0);
    chk({tag, ".wa"}, int'(wr_accept), int'(exp_wa));
    chk({tag, ".ra"}, int'(rd_accept), int'(exp_ra));
    chk({tag, ".waddr"}, int'(wr_addr), m_wr % DEPTH);
    chk({tag, ".raddr"}, int'(rd_addr), m_rd % DEPTH);
    @(posedge clk);
    m_ovf = (m_ovf && !c) || (w && m_cnt() == DEPTH);
    m_udf = (m_udf && !c) || (r && m_cnt() == 0);
    m_wr += int'(exp_wa);
    m_rd += int'(exp_ra);
    #1;
    chk_regs(tag);
    wr_en = 0; rd_en = 0; clr_err = 0;
  endtask

  task automatic model_reset();
    m_wr = 0; m_rd = 0; m_ovf = 0; m_udf = 0;
  endtask

  // Asserts reset mid-cycle and checks the asynchronous clear.
  task automatic mid_reset(input string tag);
    wr_en = 1; rd_en = 0; clr_err = 0;
    #2;
    rst = 1;
    #1;
    model_reset();
    chk_regs(tag);
    chk({tag, ".waddr"}, int'(wr_addr), 0);
    chk({tag, ".raddr"}, int'(rd_addr), 0);
    wr_en = 0;
    #2;
    rst = 0;
    @(posedge clk); #1;
    chk_regs({tag, ".post"});
  endtask

  initial begin
    #12;
    model_reset();
    chk_regs("reset");
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;

    // Fill with 16 writes.
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1, 0, 0, "fill");
      if (i == AFULL_TH - 2) chk("fill.afull_pre", int'(almost_full), 0);
      if (i == AFULL_TH - 1) chk("fill.afull_12", int'(almost_full), 1);
    end
    chk("fill.count16", int'(count), 16);
    chk("fill.full16", int'(fifo_full), 1);

    cycle(1, 0, 0, "ovf");
    chk("ovf.set", int'(overflow), 1);
    cycle(0, 0, 1, "clr");
    chk("clr.ovf", int'(overflow), 0);
    cycle(1, 1, 0, "full_rw");
    chk("full_rw.count", int'(count), 15);

    // Drain, then simultaneous request on empty.
    while (m_cnt() > 0) cycle(0, 1, 0, "drain");
    cycle(1, 1, 0, "empty_rw");
    chk("empty_rw.udf", int'(underflow), 1);
    cycle(0, 0, 1, "clr2");

    // Count 8, 40 cycles of simultaneous traffic so pointers wrap.
    while (m_cnt() < 8) cycle(1, 0, 0, "to8");
    for (int i = 0; i < 40; i++) cycle(1, 1, 0, "steady");
    chk("steady.count8", int'(count), 8);

    // Reach count 9 with overflow set, then reset mid-stream.
    while (m_cnt() < DEPTH) cycle(1, 0, 0, "to16");
    cycle(1, 0, 0, "ovf2");
    repeat (7) cycle(0, 1, 0, "to9");
    chk("to9.count", int'(count), 9);
    mid_reset("midrst");

    // Random traffic with varying write/read bias.
    for (int ph = 0; ph < 6; ph++) begin
      int pw, pr;
      pw = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 20 : 50;
      pr = 100 - pw;
      for (int i = 0; i < 150; i++) begin
        cycle($urandom_range(99) < pw, $urandom_range(99) < pr,
              $urandom_range(99) < 5, "rand");
      end
      if (ph == 3) mid_reset("rand_rst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout n_cmp=%0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
